// File: rtl/register_file.sv
// register_file
//
// Multi-ported register file with one write port and three combinational
// read ports (A, B and a debug/observation port).
//
// All state updates (reset and writes) happen on the FALLING edge of clk.
// The rising edge never touches the storage. Register 0 is hardwired to
// zero: writes to it are dropped and every read port returns 0 for it.
//
// Parameters
//   DATA_W     width of each register in bits
//   ADDR_W     address width; the file holds 2**ADDR_W registers
//
// Ports
//   clk        clock; storage updates on its falling edge
//   rst        synchronous active-high reset, sampled on the falling edge;
//              clears every register and wins over a simultaneous write
//   wr_en      write enable, sampled on the falling edge
//   wr_addr    destination register index
//   wr_data    value to write
//   rd_addr_a  read port A index      -> rd_data_a (combinational)
//   rd_addr_b  read port B index      -> rd_data_b (combinational)
//   dbg_addr   debug read index       -> dbg_data  (combinational)
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 1 << ADDR_W;

    // Full 2**ADDR_W entries so every address value decodes to exactly one
    // slot. Entry 0 is never written outside of reset and is additionally
    // masked on the read side, so it reads zero even before the first reset.
    logic [DATA_W-1:0] regs [NREGS];

    // Falling-edge update. Reset has priority; a write presented in the same
    // edge as reset is discarded.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports. No write-to-read bypass: a read of the
    // address being written shows the old contents until the falling edge
    // commits the new value.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    assign dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] dbg_data;

    int n_pass;
    int n_total;

    // Reference model: plain array of register contents, r0 kept at zero.
    logic [DATA_W-1:0] model [NREGS];

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .dbg_addr (dbg_addr),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the rules of a falling edge to the model.
    task automatic model_edge(input logic r, input logic we,
                              input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        if (r) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end else if (we && a != 0) begin
            model[a] = d;
        end
    endtask

    // Present a write between the rising and falling edges, let the falling
    // edge take it, then drop wr_en.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk); #1;
        model_edge(rst, 1'b1, a, d);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); #1;
        model_edge(1'b1, 1'b0, '0, '0);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            rd_addr_a = i[ADDR_W-1:0]; rd_addr_b = i[ADDR_W-1:0]; dbg_addr = i[ADDR_W-1:0];
            #1;
            n_total++;
            if (rd_data_a !== 32'h0) $display("FAIL reset_a r%0d got %h want 00000000", i, rd_data_a);
            else n_pass++;
            n_total++;
            if (rd_data_b !== 32'h0) $display("FAIL reset_b r%0d got %h want 00000000", i, rd_data_b);
            else n_pass++;
            n_total++;
            if (dbg_data !== 32'h0) $display("FAIL reset_dbg r%0d got %h want 00000000", i, dbg_data);
            else n_pass++;
        end
    endtask

    task automatic test_write_r5;
        do_write(5'd5, 32'hDEADBEEF);
        rd_addr_a = 5'd5; rd_addr_b = 5'd5; dbg_addr = 5'd5;
        #1;
        n_total++;
        if (rd_data_a !== 32'hDEADBEEF) $display("FAIL r5_a got %h want deadbeef", rd_data_a);
        else n_pass++;
        n_total++;
        if (rd_data_b !== 32'hDEADBEEF) $display("FAIL r5_b got %h want deadbeef", rd_data_b);
        else n_pass++;
        n_total++;
        if (dbg_data !== 32'hDEADBEEF) $display("FAIL r5_dbg got %h want deadbeef", dbg_data);
        else n_pass++;
        rd_addr_a = 5'd4; rd_addr_b = 5'd6; dbg_addr = 5'd4;
        #1;
        n_total++;
        if (rd_data_a !== 32'h0) $display("FAIL r4 got %h want 00000000", rd_data_a);
        else n_pass++;
        n_total++;
        if (rd_data_b !== 32'h0) $display("FAIL r6 got %h want 00000000", rd_data_b);
        else n_pass++;
    endtask

    task automatic test_write_r0;
        do_write(5'd0, 32'h12345678);
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; dbg_addr = 5'd0;
        #1;
        n_total++;
        if ({rd_data_a, rd_data_b, dbg_data} !== 96'h0)
            $display("FAIL r0_write got a=%h b=%h dbg=%h want all 00000000", rd_data_a, rd_data_b, dbg_data);
        else n_pass++;
        for (int i = 1; i < NREGS; i++) begin
            dbg_addr = i[ADDR_W-1:0];
            #1;
            n_total++;
            if (dbg_data !== model[i]) $display("FAIL r0_side r%0d got %h want %h", i, dbg_data, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_read_during_write;
        rd_addr_a = 5'd7;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        #1;
        n_total++;
        if (rd_data_a !== 32'h0) $display("FAIL rdw_before got %h want 00000000", rd_data_a);
        else n_pass++;
        @(negedge clk); #1;
        model_edge(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5);
        wr_en = 1'b0;
        n_total++;
        if (rd_data_a !== 32'hA5A5A5A5) $display("FAIL rdw_after got %h want a5a5a5a5", rd_data_a);
        else n_pass++;
        // The rising edge must leave it alone too.
        @(posedge clk); #1;
        n_total++;
        if (rd_data_a !== 32'hA5A5A5A5) $display("FAIL rdw_posedge got %h want a5a5a5a5", rd_data_a);
        else n_pass++;
    endtask

    task automatic test_reset_priority;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFFFFFF;
        @(negedge clk); #1;
        model_edge(1'b1, 1'b1, 5'd9, 32'hFFFFFFFF);
        rd_addr_a = 5'd9; rd_addr_b = 5'd5; dbg_addr = 5'd7;
        #1;
        n_total++;
        if (rd_data_a !== 32'h0) $display("FAIL rst_prio_r9 got %h want 00000000", rd_data_a);
        else n_pass++;
        n_total++;
        if (rd_data_b !== 32'h0) $display("FAIL rst_clear_r5 got %h want 00000000", rd_data_b);
        else n_pass++;
        n_total++;
        if (dbg_data !== 32'h0) $display("FAIL rst_clear_r7 got %h want 00000000", dbg_data);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        model_edge(1'b0, 1'b1, 5'd9, 32'hFFFFFFFF);
        wr_en = 1'b0;
        n_total++;
        if (rd_data_a !== 32'hFFFFFFFF) $display("FAIL post_rst_write got %h want ffffffff", rd_data_a);
        else n_pass++;
    endtask

    task automatic test_fill_reverse;
        logic [DATA_W-1:0] exp;
        for (int i = 1; i < NREGS; i++) begin
            exp = i * 32'h01010101;
            do_write(i[ADDR_W-1:0], exp);
        end
        for (int i = NREGS - 1; i >= 0; i--) begin
            exp = i * 32'h01010101;
            rd_addr_a = i[ADDR_W-1:0]; rd_addr_b = i[ADDR_W-1:0];
            #1;
            n_total++;
            if (rd_data_a !== exp) $display("FAIL fill_a r%0d got %h want %h", i, rd_data_a, exp);
            else n_pass++;
            n_total++;
            if (rd_data_b !== exp) $display("FAIL fill_b r%0d got %h want %h", i, rd_data_b, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic              r, we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            r  = ($urandom_range(0, 39) == 0);
            we = $urandom_range(0, 1);
            a  = ADDR_W'($urandom_range(0, NREGS - 1));
            d  = $urandom;
            rst = r; wr_en = we; wr_addr = a; wr_data = d;
            rd_addr_a = ADDR_W'($urandom_range(0, NREGS - 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? a : ADDR_W'($urandom_range(0, NREGS - 1));
            dbg_addr  = ($urandom_range(0, 3) == 0) ? rd_addr_a : ADDR_W'($urandom_range(0, NREGS - 1));
            #1;
            n_total++;
            if (rd_data_a !== model[rd_addr_a] || rd_data_b !== model[rd_addr_b] || dbg_data !== model[dbg_addr])
                $display("FAIL rand_pre n=%0d a=%h/%h b=%h/%h dbg=%h/%h (got/want)", n,
                         rd_data_a, model[rd_addr_a], rd_data_b, model[rd_addr_b], dbg_data, model[dbg_addr]);
            else n_pass++;
            @(negedge clk); #1;
            model_edge(r, we, a, d);
            n_total++;
            if (rd_data_a !== model[rd_addr_a] || rd_data_b !== model[rd_addr_b] || dbg_data !== model[dbg_addr])
                $display("FAIL rand_post n=%0d a=%h/%h b=%h/%h dbg=%h/%h (got/want)", n,
                         rd_data_a, model[rd_addr_a], rd_data_b, model[rd_addr_b], dbg_data, model[dbg_addr]);
            else n_pass++;
        end
        rst = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; dbg_addr = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        test_reset;
        test_write_r5;
        test_write_r0;
        test_read_during_write;
        test_reset_priority;
        test_fill_reverse;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32: width of each register in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; register count = 2^ADDR_W.
REQ-003 clk  input  1  clock; all register writes occur only on the falling edge.
REQ-004 rst  input  1  reset, synchronous, active-high, sampled on the falling edge of clk.
REQ-005 wr_en  input  1  write enable, sampled on the falling edge of clk.
REQ-006 wr_addr  input  ADDR_W  destination register index.
REQ-007 wr_data  input  DATA_W  value to write.
REQ-008 rd_addr_a  input  ADDR_W  read port A register index.
REQ-009 rd_addr_b  input  ADDR_W  read port B register index.
REQ-010 rd_data_a  output  DATA_W  contents of register rd_addr_a.
REQ-011 rd_data_b  output  DATA_W  contents of register rd_addr_b.
REQ-012 dbg_addr  input  ADDR_W  debug/observation read index.
REQ-013 dbg_data  output  DATA_W  contents of register dbg_addr.

Function
REQ-014 Storage SHALL be 2^ADDR_W registers, each DATA_W bits wide, indexed 0 to 2^ADDR_W-1.
REQ-015 Register 0 SHALL always read as zero, and writes to it SHALL be ignored.
REQ-016 On a falling clk edge with rst=0, wr_en=1 and wr_addr!=0, register wr_addr SHALL take wr_data.
REQ-017 On a falling clk edge with wr_en=0, no register SHALL change.
REQ-018 The rising clk edge SHALL NOT modify any register.
REQ-019 Read ports A, B and dbg SHALL be combinational, with zero cycle latency from address change to data.
REQ-020 All three read ports SHALL be independent, and any two SHALL be allowed to address the same register simultaneously.
REQ-021 Read-during-write: before the falling edge, a read of wr_addr SHALL return the old value; after the falling edge it SHALL return wr_data; no forwarding path SHALL exist.
REQ-022 The write and read address fields SHALL use full-range decode with no aliasing and no out-of-range case.
REQ-023 No output SHALL ever be X or Z once reset has been applied.

Reset
REQ-024 On a falling clk edge with rst=1, all registers SHALL clear to 0.
REQ-025 rst SHALL take priority over a simultaneous write, and that write SHALL be discarded.
REQ-026 Within one half-cycle after the reset edge, rd_data_a, rd_data_b and dbg_data SHALL read 0 for every address.
REQ-027 Asserting rst mid-operation SHALL clear all previously written values.
REQ-028 Deasserting rst SHALL allow a write on the very next falling edge.

Verification
REQ-029 Reset, then sweep all 32 addresses on each read port -> every port reads 0x00000000.
REQ-030 Write 0xDEADBEEF to r5, then set rd_addr_a=5, rd_addr_b=5, dbg_addr=5 -> all three ports read 0xDEADBEEF; r4 and r6 read 0.
REQ-031 Write 0x12345678 to r0 -> r0 reads 0 on all ports; all other registers are unchanged.
REQ-032 Hold rd_addr_a=7 and write 0xA5A5A5A5 to r7 -> rd_data_a reads old value 0 before the falling edge and 0xA5A5A5A5 after it.
REQ-033 Hold wr_en=1, wr_addr=9, wr_data=0xFFFFFFFF with rst=1 at a falling edge -> r9 reads 0; with rst=0 at the next falling edge -> r9 reads 0xFFFFFFFF.
REQ-034 Write a distinct value (index*0x01010101) to r1..r31, then read all registers with port A and port B in reverse order -> each register matches its value; r0 reads 0.
